ahb_slave_port_mux: RTL and testbench

Slave-side address/data multiplexer that sits directly downstream of a per-slave AHB arbiter. It uses the arbiter's one-hot grant to route one master's address-phase signals to the slave. It tracks which master owns the pipelined data phase and routes write data, read data, ready and response accordingly. It also returns the slave's wait state to the arbiter as `hwait`.

---
 rtl/ahb_slave_port_mux_if.sv | 62 ++++++
 rtl/ahb_slave_port_mux.sv | 142 ++++++++++++++
 tb/tb_ahb_slave_port_mux.sv | 444 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_slave_port_mux_if.sv
// ahb_slave_port_mux_if
// Bundle of the arbiter, per-master and slave-side signals around one AHB
// slave port multiplexer.
//   slave  modport : view of the multiplexer itself
//   master modport : view of the surrounding fabric (masters, arbiter, slave)
// Signals:
//   hgrant                     one-hot grant from the arbiter (masked by ~hwait)
//   m_haddr/htrans/hwrite/hsize/hburst/hwdata   per-master address/data phase
//   m_hready/m_hresp           per-master handshake back to the masters
//   m_hrdata                   read data broadcast to all masters
//   s_hsel..s_hwdata           muxed slave-side request
//   s_hreadyout/s_hresp/s_hrdata  slave response
//   hwait                      slave wait state fed back to the arbiter
//   xfer_cnt                   completed data phases (wraps)
//   grant_err                  sticky flag for a non-one-hot grant
interface ahb_slave_port_mux_if #(
    parameter int MASTER_NUM = 2,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32
);
    logic [MASTER_NUM-1:0]             hgrant;
    logic [MASTER_NUM-1:0][ADDR_W-1:0] m_haddr;
    logic [MASTER_NUM-1:0][1:0]        m_htrans;
    logic [MASTER_NUM-1:0]             m_hwrite;
    logic [MASTER_NUM-1:0][2:0]        m_hsize;
    logic [MASTER_NUM-1:0][2:0]        m_hburst;
    logic [MASTER_NUM-1:0][DATA_W-1:0] m_hwdata;
    logic [MASTER_NUM-1:0]             m_hready;
    logic [MASTER_NUM-1:0]             m_hresp;
    logic [DATA_W-1:0]                 m_hrdata;

    logic                              s_hsel;
    logic [ADDR_W-1:0]                 s_haddr;
    logic [1:0]                        s_htrans;
    logic                              s_hwrite;
    logic [2:0]                        s_hsize;
    logic [2:0]                        s_hburst;
    logic [DATA_W-1:0]                 s_hwdata;
    logic                              s_hreadyout;
    logic                              s_hresp;
    logic [DATA_W-1:0]                 s_hrdata;

    logic                              hwait;
    logic [15:0]                       xfer_cnt;
    logic                              grant_err;

    modport slave (
        input  hgrant, m_haddr, m_htrans, m_hwrite, m_hsize, m_hburst, m_hwdata,
        input  s_hreadyout, s_hresp, s_hrdata,
        output m_hready, m_hresp, m_hrdata,
        output s_hsel, s_haddr, s_htrans, s_hwrite, s_hsize, s_hburst, s_hwdata,
        output hwait, xfer_cnt, grant_err
    );

    modport master (
        output hgrant, m_haddr, m_htrans, m_hwrite, m_hsize, m_hburst, m_hwdata,
        output s_hreadyout, s_hresp, s_hrdata,
        input  m_hready, m_hresp, m_hrdata,
        input  s_hsel, s_haddr, s_htrans, s_hwrite, s_hsize, s_hburst, s_hwdata,
        input  hwait, xfer_cnt, grant_err
    );
endinterface

// File: rtl/ahb_slave_port_mux.sv
// ahb_slave_port_mux
// Slave-side address/data multiplexer placed after a per-slave AHB arbiter.
// The address phase is routed combinationally from the granted master (held
// through wait states); the data phase is routed from the master that owned
// the previously accepted address phase.
// Ports:
//   hclk      clock
//   hreset_n  asynchronous active-low reset
//   bus       ahb_slave_port_mux_if.slave (see interface header for signals)
// Optional build macro:
//   AHB_SLAVE_MUX_ERR_ABORT_EN  on the first ERROR cycle the pipelined address
//                               is cancelled (s_hsel/s_htrans forced idle) and
//                               the held owner is dropped on the second cycle.
module ahb_slave_port_mux #(
    parameter int MASTER_NUM = 2,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32
) (
    input  logic                 hclk,
    input  logic                 hreset_n,
    ahb_slave_port_mux_if.slave  bus
);

    logic [MASTER_NUM-1:0] r_addr_hold;
    logic [MASTER_NUM-1:0] r_data_owner;
    logic                  r_data_valid;
    logic [15:0]           r_xfer_cnt;
    logic                  r_grant_err;

    logic [MASTER_NUM-1:0] w_grant_lsb;
    logic [MASTER_NUM-1:0] w_addr_sel;
    logic                  w_grant_multi;
    logic                  w_abort;
    logic                  w_err_clr;
    logic                  w_hsel;
    logic [ADDR_W-1:0]     w_haddr;
    logic [1:0]            w_htrans_mux;
    logic [1:0]            w_htrans;
    logic                  w_hwrite;
    logic [2:0]            w_hsize;
    logic [2:0]            w_hburst;
    logic [DATA_W-1:0]     w_hwdata;
    logic [MASTER_NUM-1:0] w_hready;
    logic [MASTER_NUM-1:0] w_hresp;

    // Lowest set bit wins when the arbiter misbehaves; scanning downward lets
    // each lower set bit overwrite any higher one.
    always_comb begin
        w_grant_lsb = '0;
        for (int i = MASTER_NUM - 1; i >= 0; i--) begin
            if (bus.hgrant[i]) begin
                w_grant_lsb    = '0;
                w_grant_lsb[i] = 1'b1;
            end
        end
    end

    assign w_grant_multi = ($countones(bus.hgrant) > 1);

    // The arbiter masks hgrant during wait states, so the held owner keeps the
    // address stable. Gated by reset so every slave-side output is quiet while
    // reset is asserted, independent of what the arbiter drives.
    assign w_addr_sel = !hreset_n        ? '0 :
                        bus.s_hreadyout  ? w_grant_lsb : r_addr_hold;

`ifdef AHB_SLAVE_MUX_ERR_ABORT_EN
    assign w_abort   = r_data_valid & bus.s_hresp & ~bus.s_hreadyout;
    assign w_err_clr = r_data_valid & bus.s_hresp &  bus.s_hreadyout;
`else
    assign w_abort   = 1'b0;
    assign w_err_clr = 1'b0;
`endif

    always_comb begin
        w_haddr      = '0;
        w_htrans_mux = '0;
        w_hwrite     = 1'b0;
        w_hsize      = '0;
        w_hburst     = '0;
        w_hwdata     = '0;
        for (int i = 0; i < MASTER_NUM; i++) begin
            w_haddr      = w_haddr      | (bus.m_haddr[i]  & {ADDR_W{w_addr_sel[i]}});
            w_htrans_mux = w_htrans_mux | (bus.m_htrans[i] & {2{w_addr_sel[i]}});
            w_hwrite     = w_hwrite     | (bus.m_hwrite[i] & w_addr_sel[i]);
            w_hsize      = w_hsize      | (bus.m_hsize[i]  & {3{w_addr_sel[i]}});
            w_hburst     = w_hburst     | (bus.m_hburst[i] & {3{w_addr_sel[i]}});
            w_hwdata     = w_hwdata     |
                           (bus.m_hwdata[i] & {DATA_W{r_data_valid & r_data_owner[i]}});
        end
    end

    assign w_hsel   = (|w_addr_sel) & ~w_abort;
    assign w_htrans = w_abort ? 2'b00 : w_htrans_mux;

    always_comb begin
        w_hready = '1;
        w_hresp  = '0;
        for (int i = 0; i < MASTER_NUM; i++) begin
            if (r_data_valid & r_data_owner[i]) begin
                w_hready[i] = bus.s_hreadyout;
                w_hresp[i]  = bus.s_hresp;
            end
        end
    end

    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            r_addr_hold  <= '0;
            r_data_owner <= '0;
            r_data_valid <= 1'b0;
            r_xfer_cnt   <= '0;
            r_grant_err  <= 1'b0;
        end else begin
            r_addr_hold <= w_err_clr ? '0 : w_addr_sel;
            if (bus.s_hreadyout) begin
                r_data_owner <= w_addr_sel;
                r_data_valid <= w_hsel & w_htrans[1];
            end
            if (r_data_valid & bus.s_hreadyout) begin
                r_xfer_cnt <= r_xfer_cnt + 16'd1;
            end
            if (w_grant_multi) begin
                r_grant_err <= 1'b1;
            end
        end
    end

    assign bus.s_hsel    = w_hsel;
    assign bus.s_haddr   = w_haddr;
    assign bus.s_htrans  = w_htrans;
    assign bus.s_hwrite  = w_hwrite;
    assign bus.s_hsize   = w_hsize;
    assign bus.s_hburst  = w_hburst;
    assign bus.s_hwdata  = w_hwdata;
    assign bus.m_hready  = w_hready;
    assign bus.m_hresp   = w_hresp;
    assign bus.m_hrdata  = bus.s_hrdata;
    assign bus.hwait     = r_data_valid & ~bus.s_hreadyout;
    assign bus.xfer_cnt  = r_xfer_cnt;
    assign bus.grant_err = r_grant_err;

endmodule

// File: tb/tb_ahb_slave_port_mux.sv
module tb_ahb_slave_port_mux;
    localparam int MN = 2;
    localparam int AW = 32;
    localparam int DW = 32;

    logic hclk = 1'b0;
    logic hreset_n = 1'b0;
    always #5 hclk = ~hclk;

    ahb_slave_port_mux_if #(.MASTER_NUM(MN), .ADDR_W(AW), .DATA_W(DW)) bus ();

    ahb_slave_port_mux #(.MASTER_NUM(MN), .ADDR_W(AW), .DATA_W(DW)) dut (
        .hclk     (hclk),
        .hreset_n (hreset_n),
        .bus      (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: who holds the address, who owns the data phase
    // (-1 = nobody), how many data phases completed, whether a bad grant was seen.
    int          mdl_hold;
    int          mdl_dp;
    int unsigned mdl_cnt;
    bit          mdl_gerr;
    int          cur_sel;

    logic          exp_hsel;
    logic [AW-1:0] exp_haddr;
    logic [1:0]    exp_htrans;
    logic          exp_hwrite;
    logic [2:0]    exp_hsize;
    logic [2:0]    exp_hburst;
    logic [DW-1:0] exp_hwdata;
    logic [MN-1:0] exp_hready;
    logic [MN-1:0] exp_hresp;
    logic          exp_hwait;

    function automatic int lowest(input logic [MN-1:0] g);
        for (int i = 0; i < MN; i++) if (g[i]) return i;
        return -1;
    endfunction

    function automatic bit abort_enabled();
`ifdef AHB_SLAVE_MUX_ERR_ABORT_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        mdl_hold = -1;
        mdl_dp   = -1;
        mdl_cnt  = 0;
        mdl_gerr = 1'b0;
    endtask

    task automatic idle_inputs();
        bus.hgrant      = '0;
        bus.m_haddr     = '0;
        bus.m_htrans    = '0;
        bus.m_hwrite    = '0;
        bus.m_hsize     = '0;
        bus.m_hburst    = '0;
        bus.m_hwdata    = '0;
        bus.s_hreadyout = 1'b1;
        bus.s_hresp     = 1'b0;
        bus.s_hrdata    = '0;
    endtask

    task automatic set_m(input int i, input logic [AW-1:0] a, input logic [1:0] t,
                         input logic w, input logic [2:0] sz, input logic [2:0] bu,
                         input logic [DW-1:0] wd);
        bus.m_haddr[i]  = a;
        bus.m_htrans[i] = t;
        bus.m_hwrite[i] = w;
        bus.m_hsize[i]  = sz;
        bus.m_hburst[i] = bu;
        bus.m_hwdata[i] = wd;
    endtask

    task automatic do_reset();
        hreset_n = 1'b0;
        idle_inputs();
        @(posedge hclk);
        #1;
        hreset_n = 1'b1;
        model_reset();
    endtask

    // Let inputs settle, then compute this cycle's expected outputs.
    task automatic settle();
        bit abort;
        #2;
        cur_sel = bus.s_hreadyout ? lowest(bus.hgrant) : mdl_hold;
        abort = abort_enabled() && mdl_dp >= 0 && bus.s_hresp && !bus.s_hreadyout;
        exp_hsel   = (cur_sel >= 0) && !abort;
        exp_haddr  = (cur_sel >= 0) ? bus.m_haddr[cur_sel] : '0;
        exp_htrans = (cur_sel >= 0 && !abort) ? bus.m_htrans[cur_sel] : 2'b00;
        exp_hwrite = (cur_sel >= 0) ? bus.m_hwrite[cur_sel] : 1'b0;
        exp_hsize  = (cur_sel >= 0) ? bus.m_hsize[cur_sel] : 3'd0;
        exp_hburst = (cur_sel >= 0) ? bus.m_hburst[cur_sel] : 3'd0;
        exp_hwdata = (mdl_dp >= 0) ? bus.m_hwdata[mdl_dp] : '0;
        for (int i = 0; i < MN; i++) begin
            exp_hready[i] = (mdl_dp == i) ? bus.s_hreadyout : 1'b1;
            exp_hresp[i]  = (mdl_dp == i) ? bus.s_hresp : 1'b0;
        end
        exp_hwait = (mdl_dp >= 0) && !bus.s_hreadyout;
    endtask

    // Advance one clock and update the model with what the slave saw.
    task automatic tick();
        bit rdy, rsp, multi, started;
        int old_dp;
        rdy     = bus.s_hreadyout;
        rsp     = bus.s_hresp;
        multi   = ($countones(bus.hgrant) > 1);
        started = (cur_sel >= 0) && bus.m_htrans[cur_sel][1];
        old_dp  = mdl_dp;
        @(posedge hclk);
        if (old_dp >= 0 && rdy) mdl_cnt++;
        if (rdy) mdl_dp = started ? cur_sel : -1;
        mdl_hold = cur_sel;
        if (abort_enabled() && old_dp >= 0 && rsp && rdy) mdl_hold = -1;
        if (multi) mdl_gerr = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        hreset_n = 1'b0;
        idle_inputs();
        #3;
        checks++;
        if ({bus.s_hsel, bus.s_haddr, bus.s_htrans, bus.s_hwrite, bus.s_hsize,
             bus.s_hburst, bus.s_hwdata} !== '0) begin
            errors++;
            $display("FAIL reset_s_outputs: got sel=%b addr=%h trans=%b wdata=%h, expected all 0",
                     bus.s_hsel, bus.s_haddr, bus.s_htrans, bus.s_hwdata);
        end
        checks++;
        if ({bus.m_hready, bus.m_hresp, bus.hwait, bus.xfer_cnt, bus.grant_err} !==
            {2'b11, 2'b00, 1'b0, 16'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_status: got hready=%b hresp=%b hwait=%b cnt=%0d gerr=%b, expected 11 00 0 0 0",
                     bus.m_hready, bus.m_hresp, bus.hwait, bus.xfer_cnt, bus.grant_err);
        end
        @(posedge hclk);
        #1;
        hreset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_single_write();
        do_reset();
        bus.hgrant = 2'b01;
        set_m(0, 32'h100, 2'd2, 1'b1, 3'd2, 3'd0, 32'h0);
        settle();
        checks++;
        if (bus.s_haddr !== 32'h100 || bus.s_hsel !== 1'b1 || bus.s_hwrite !== 1'b1) begin
            errors++;
            $display("FAIL single_write_addr: got addr=%h sel=%b write=%b, expected 100 1 1",
                     bus.s_haddr, bus.s_hsel, bus.s_hwrite);
        end
        tick();
        bus.hgrant = 2'b00;
        set_m(0, 32'h0, 2'd0, 1'b0, 3'd0, 3'd0, 32'hA5A5A5A5);
        settle();
        checks++;
        if (bus.s_hwdata !== 32'hA5A5A5A5 || bus.m_hready !== 2'b11) begin
            errors++;
            $display("FAIL single_write_data: got wdata=%h hready=%b, expected a5a5a5a5 11",
                     bus.s_hwdata, bus.m_hready);
        end
        tick();
        checks++;
        if (bus.xfer_cnt !== 16'd1) begin
            errors++;
            $display("FAIL single_write_cnt: got %0d expected 1", bus.xfer_cnt);
        end
    endtask

    task automatic test_wait_states();
        logic [AW-1:0] addr_t [7] = '{32'h200, 32'h204, 32'h208, 32'h208, 32'h208, 32'h20C, 32'h0};
        logic [1:0]    trans_t[7] = '{2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd0};
        logic [1:0]    grant_t[7] = '{2'b10, 2'b10, 2'b00, 2'b00, 2'b10, 2'b10, 2'b00};
        logic          rdy_t  [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        int  wait_cycles = 0;
        bit  m0_low = 1'b0;
        do_reset();
        for (int c = 0; c < 7; c++) begin
            bus.hgrant      = grant_t[c];
            bus.s_hreadyout = rdy_t[c];
            bus.s_hrdata    = $urandom;
            set_m(1, addr_t[c], trans_t[c], 1'b0, 3'd2, 3'd3, 32'h0);
            settle();
            if (bus.hwait === 1'b1) wait_cycles++;
            if (bus.m_hready[0] !== 1'b1) m0_low = 1'b1;
            if (!rdy_t[c]) begin
                checks++;
                if (bus.s_haddr !== 32'h208 || bus.m_hready !== 2'b01) begin
                    errors++;
                    $display("FAIL wait_hold cycle %0d: got addr=%h hready=%b, expected 208 01",
                             c, bus.s_haddr, bus.m_hready);
                end
            end
            tick();
        end
        checks++;
        if (wait_cycles != 2) begin
            errors++;
            $display("FAIL wait_hwait_cycles: got %0d expected 2", wait_cycles);
        end
        checks++;
        if (m0_low) begin
            errors++;
            $display("FAIL wait_m0_ready: got m_hready[0] low at some cycle, expected 1 throughout");
        end
        checks++;
        if (bus.xfer_cnt !== 16'd4) begin
            errors++;
            $display("FAIL wait_cnt: got %0d expected 4", bus.xfer_cnt);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus.hgrant = 2'b01;
        set_m(0, 32'h300, 2'd2, 1'b1, 3'd2, 3'd0, 32'h0);
        settle();
        tick();
        bus.hgrant = 2'b10;
        set_m(0, 32'h0, 2'd0, 1'b0, 3'd0, 3'd0, 32'h11112222);
        set_m(1, 32'h400, 2'd2, 1'b0, 3'd2, 3'd0, 32'h33334444);
        settle();
        checks++;
        if (bus.s_hwdata !== 32'h11112222 || bus.s_haddr !== 32'h400 || bus.s_hwrite !== 1'b0) begin
            errors++;
            $display("FAIL handover_overlap: got wdata=%h addr=%h write=%b, expected 11112222 400 0",
                     bus.s_hwdata, bus.s_haddr, bus.s_hwrite);
        end
        tick();
        bus.hgrant      = 2'b00;
        bus.s_hreadyout = 1'b0;
        bus.s_hrdata    = 32'hDEADBEEF;
        set_m(1, 32'h0, 2'd0, 1'b0, 3'd0, 3'd0, 32'h0);
        settle();
        checks++;
        if (bus.m_hready !== 2'b01 || bus.m_hrdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL handover_read_wait: got hready=%b rdata=%h, expected 01 deadbeef",
                     bus.m_hready, bus.m_hrdata);
        end
        tick();
        bus.s_hreadyout = 1'b1;
        bus.s_hrdata    = 32'hCAFEF00D;
        settle();
        checks++;
        if (bus.m_hready !== 2'b11 || bus.m_hrdata !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL handover_read_done: got hready=%b rdata=%h, expected 11 cafef00d",
                     bus.m_hready, bus.m_hrdata);
        end
        tick();
    endtask

    task automatic test_error();
        logic [1:0] exp_tr;
        do_reset();
        bus.hgrant = 2'b01;
        set_m(0, 32'h500, 2'd2, 1'b1, 3'd2, 3'd0, 32'h0);
        settle();
        tick();
        bus.hgrant      = 2'b00;
        bus.s_hreadyout = 1'b0;
        bus.s_hresp     = 1'b1;
        set_m(0, 32'h504, 2'd2, 1'b1, 3'd2, 3'd0, 32'h5555AAAA);
        settle();
        exp_tr = abort_enabled() ? 2'd0 : 2'd2;
        checks++;
        if (bus.m_hresp !== 2'b01 || bus.m_hready !== 2'b10) begin
            errors++;
            $display("FAIL error_first_resp: got hresp=%b hready=%b, expected 01 10",
                     bus.m_hresp, bus.m_hready);
        end
        checks++;
        if (bus.s_htrans !== exp_tr) begin
            errors++;
            $display("FAIL error_first_htrans: got %0d expected %0d", bus.s_htrans, exp_tr);
        end
        tick();
        bus.hgrant      = 2'b01;
        bus.s_hreadyout = 1'b1;
        set_m(0, 32'h0, 2'd0, 1'b0, 3'd0, 3'd0, 32'h0);
        settle();
        checks++;
        if (bus.m_hresp !== 2'b01 || bus.m_hready !== 2'b11) begin
            errors++;
            $display("FAIL error_second_resp: got hresp=%b hready=%b, expected 01 11",
                     bus.m_hresp, bus.m_hready);
        end
        tick();
        bus.hgrant  = 2'b00;
        bus.s_hresp = 1'b0;
        settle();
        tick();
    endtask

    task automatic test_bad_grant();
        do_reset();
        bus.hgrant = 2'b11;
        set_m(0, 32'h600, 2'd2, 1'b0, 3'd2, 3'd0, 32'h0);
        set_m(1, 32'h700, 2'd2, 1'b1, 3'd1, 3'd0, 32'h0);
        settle();
        checks++;
        if (bus.s_haddr !== 32'h600 || bus.s_hwrite !== 1'b0) begin
            errors++;
            $display("FAIL bad_grant_route: got addr=%h write=%b, expected 600 0",
                     bus.s_haddr, bus.s_hwrite);
        end
        tick();
        idle_inputs();
        for (int c = 0; c < 4; c++) begin
            settle();
            checks++;
            if (bus.grant_err !== 1'b1) begin
                errors++;
                $display("FAIL bad_grant_sticky cycle %0d: got %b expected 1", c, bus.grant_err);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        bus.hgrant = 2'b01;
        set_m(0, 32'h800, 2'd2, 1'b1, 3'd2, 3'd3, 32'h0);
        settle();
        tick();
        set_m(0, 32'h804, 2'd3, 1'b1, 3'd2, 3'd3, 32'h01010101);
        settle();
        tick();
        set_m(0, 32'h808, 2'd3, 1'b1, 3'd2, 3'd3, 32'h02020202);
        settle();
        checks++;
        if (bus.xfer_cnt !== 16'd1 || bus.s_hwdata !== 32'h02020202) begin
            errors++;
            $display("FAIL mid_burst_pre: got cnt=%0d wdata=%h, expected 1 02020202",
                     bus.xfer_cnt, bus.s_hwdata);
        end
        hreset_n = 1'b0;
        #1;
        checks++;
        if ({bus.s_hsel, bus.s_haddr, bus.s_htrans, bus.s_hwdata, bus.m_hready, bus.m_hresp,
             bus.hwait, bus.xfer_cnt, bus.grant_err} !==
            {1'b0, 32'h0, 2'b00, 32'h0, 2'b11, 2'b00, 1'b0, 16'd0, 1'b0}) begin
            errors++;
            $display("FAIL mid_burst_async: got sel=%b addr=%h wdata=%h hready=%b hwait=%b cnt=%0d, expected 0 0 0 11 0 0",
                     bus.s_hsel, bus.s_haddr, bus.s_hwdata, bus.m_hready, bus.hwait, bus.xfer_cnt);
        end
        @(posedge hclk);
        #1;
        hreset_n = 1'b1;
        model_reset();
        bus.hgrant = 2'b00;
        settle();
        checks++;
        if (bus.s_hwdata !== 32'h0 || bus.xfer_cnt !== 16'd0) begin
            errors++;
            $display("FAIL mid_burst_after: got wdata=%h cnt=%0d, expected 0 0",
                     bus.s_hwdata, bus.xfer_cnt);
        end
        tick();
        checks++;
        if (bus.xfer_cnt !== 16'd0) begin
            errors++;
            $display("FAIL mid_burst_cnt: got %0d expected 0", bus.xfer_cnt);
        end
    endtask

    task automatic test_random();
        logic [1:0] gsel;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            bus.s_hreadyout = (mdl_dp >= 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
            bus.s_hresp     = 1'b0;
            bus.s_hrdata    = $urandom;
            gsel = 2'($urandom_range(0, 2));
            bus.hgrant = ((mdl_dp >= 0) && !bus.s_hreadyout) ? 2'b00 :
                         (gsel == 2'd1) ? 2'b01 : (gsel == 2'd2) ? 2'b10 : 2'b00;
            for (int i = 0; i < MN; i++) begin
                set_m(i, $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                      3'($urandom_range(0, 2)), 3'($urandom_range(0, 7)), $urandom);
            end
            settle();
            checks++;
            if ({bus.s_hsel, bus.s_haddr, bus.s_htrans, bus.s_hwrite, bus.s_hsize, bus.s_hburst} !==
                {exp_hsel, exp_haddr, exp_htrans, exp_hwrite, exp_hsize, exp_hburst}) begin
                errors++;
                $display("FAIL rand_addr cycle %0d: got sel=%b addr=%h trans=%0d w=%b sz=%0d bu=%0d, expected %b %h %0d %b %0d %0d",
                         c, bus.s_hsel, bus.s_haddr, bus.s_htrans, bus.s_hwrite, bus.s_hsize, bus.s_hburst,
                         exp_hsel, exp_haddr, exp_htrans, exp_hwrite, exp_hsize, exp_hburst);
            end
            checks++;
            if ({bus.s_hwdata, bus.m_hready, bus.m_hresp, bus.hwait, bus.m_hrdata} !==
                {exp_hwdata, exp_hready, exp_hresp, exp_hwait, bus.s_hrdata}) begin
                errors++;
                $display("FAIL rand_data cycle %0d: got wdata=%h hready=%b hresp=%b hwait=%b, expected %h %b %b %b",
                         c, bus.s_hwdata, bus.m_hready, bus.m_hresp, bus.hwait,
                         exp_hwdata, exp_hready, exp_hresp, exp_hwait);
            end
            tick();
            checks++;
            if (bus.xfer_cnt !== mdl_cnt[15:0] || bus.grant_err !== mdl_gerr) begin
                errors++;
                $display("FAIL rand_status cycle %0d: got cnt=%0d gerr=%b, expected %0d %b",
                         c, bus.xfer_cnt, bus.grant_err, mdl_cnt[15:0], mdl_gerr);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        idle_inputs();
        cur_sel = -1;
        test_reset();
        test_single_write();
        test_wait_states();
        test_back_to_back();
        test_error();
        test_bad_grant();
        test_reset_mid_burst();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
